l2_req_sequencer: RTL and testbench

- Front-end controller for the L2 cache model. Accepts requests from three sources: the L1 data side, the L1 instruction side and the bus snoop side.
- Arbitrates among them and sequences exactly one cache operation at a time: lookup, then an optional memory fill on a miss, then a response.
- Maintains the hit, read and write statistics counters used for the end-of-trace report.
- Sits between the L1/snoop request interfaces and the L2 tag/MESI array.

---
 rtl/l2_pkg.sv | 34 +++
 rtl/l2_stat_counter.sv | 36 +++
 rtl/l2_req_sequencer.sv | 172 +++++++++++++++++
 tb/tb_l2_req_sequencer.sv | 499 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_pkg.sv
// Shared definitions for the L2 request front end: trace command codes,
// request source encodings, sequencer states and snoop result codes.
package l2_pkg;

    // Trace command codes carried on lk_cmd
    localparam logic [3:0] CMD_DREAD    = 4'd0;
    localparam logic [3:0] CMD_DWRITE   = 4'd1;
    localparam logic [3:0] CMD_IFETCH   = 4'd2;
    localparam logic [3:0] CMD_SNP_INV  = 4'd3;
    localparam logic [3:0] CMD_SNP_RD   = 4'd4;
    localparam logic [3:0] CMD_SNP_WR   = 4'd5;
    localparam logic [3:0] CMD_SNP_RFO  = 4'd6;
    localparam logic [3:0] CMD_RSVD7    = 4'd7;
    localparam logic [3:0] CMD_CLEAR    = 4'd8;
    localparam logic [3:0] CMD_PRINT    = 4'd9;

    // Request sources as reported on rsp_src
    localparam logic [1:0] SRC_L1D = 2'd0;
    localparam logic [1:0] SRC_L1I = 2'd1;
    localparam logic [1:0] SRC_SNP = 2'd2;

    // Snoop result codes returned to the bus model
    localparam logic [1:0] HIT   = 2'd0;
    localparam logic [1:0] HITM  = 2'd1;
    localparam logic [1:0] NOHIT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_FILL,
        ST_RESP
    } state_e;

endpackage

// File: rtl/l2_stat_counter.sv
// Saturating statistics counter with synchronous clear; clear wins over
// a simultaneous increment.
module l2_stat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear first, otherwise increment unless already saturated
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/l2_req_sequencer.sv
// L2 request sequencer: arbitrates snoop / L1D / L1I requests and runs one
// lookup -> optional fill -> response sequence at a time, keeping L1-side
// hit/read/write statistics.
module l2_req_sequencer
    import l2_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              l1d_valid,
    input  logic              l1d_we,
    input  logic [ADDR_W-1:0] l1d_addr,
    output logic              l1d_ready,
    input  logic              l1i_valid,
    input  logic [ADDR_W-1:0] l1i_addr,
    output logic              l1i_ready,
    input  logic              snp_valid,
    input  logic [1:0]        snp_op,
    input  logic [ADDR_W-1:0] snp_addr,
    output logic              snp_ready,
    output logic              lk_valid,
    output logic [3:0]        lk_cmd,
    output logic [ADDR_W-1:0] lk_addr,
    input  logic              lk_done,
    input  logic              lk_hit,
    output logic              fill_req,
    input  logic              fill_done,
    output logic              rsp_valid,
    output logic [1:0]        rsp_src,
    output logic              rsp_hit,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  read_cnt,
    output logic [CNT_W-1:0]  write_cnt
);

    state_e            state_q, state_d;
    logic              rr_q, rr_d;      // 0: L1D wins a tie, 1: L1I wins
    logic [3:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        src_q, src_d;
    logic              hit_q, hit_d;

    logic gnt_snp, gnt_l1d, gnt_l1i;
    logic is_l1;

    // Grant: snoop first, then round-robin between the two L1 ports (idle only)
    always_comb begin
        gnt_snp = 1'b0;
        gnt_l1d = 1'b0;
        gnt_l1i = 1'b0;
        if ((state_q == ST_IDLE) && rst_n) begin
            if (snp_valid) begin
                gnt_snp = 1'b1;
            end else if (l1d_valid && (!l1i_valid || !rr_q)) begin
                gnt_l1d = 1'b1;
            end else if (l1i_valid) begin
                gnt_l1i = 1'b1;
            end
        end
    end

    // Next-state and operation capture
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        src_d   = src_q;
        hit_d   = hit_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_snp) begin
                    cmd_d   = CMD_SNP_INV + {2'b00, snp_op};
                    addr_d  = snp_addr;
                    src_d   = SRC_SNP;
                    hit_d   = 1'b0;
                    state_d = ST_LOOKUP;
                end else if (gnt_l1d) begin
                    cmd_d   = l1d_we ? CMD_DWRITE : CMD_DREAD;
                    addr_d  = l1d_addr;
                    src_d   = SRC_L1D;
                    hit_d   = 1'b0;
                    rr_d    = 1'b1;
                    state_d = ST_LOOKUP;
                end else if (gnt_l1i) begin
                    cmd_d   = CMD_IFETCH;
                    addr_d  = l1i_addr;
                    src_d   = SRC_L1I;
                    hit_d   = 1'b0;
                    rr_d    = 1'b0;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (lk_done) begin
                    hit_d   = lk_hit;
                    state_d = (lk_hit || (src_q == SRC_SNP)) ? ST_RESP : ST_FILL;
                end
            end
            ST_FILL: begin
                if (fill_done) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and latched operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rr_q    <= 1'b0;
            cmd_q   <= '0;
            addr_q  <= '0;
            src_q   <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            src_q   <= src_d;
            hit_q   <= hit_d;
        end
    end

    assign snp_ready = gnt_snp;
    assign l1d_ready = gnt_l1d;
    assign l1i_ready = gnt_l1i;
    assign lk_valid  = (state_q == ST_LOOKUP);
    assign lk_cmd    = cmd_q;
    assign lk_addr   = addr_q;
    assign fill_req  = (state_q == ST_FILL);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_src   = rsp_valid ? src_q : '0;
    assign rsp_hit   = rsp_valid & hit_q;
    assign is_l1     = (src_q != SRC_SNP);

    l2_stat_counter #(.W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (rsp_valid & is_l1 & hit_q),
        .clr_i (clr_stats),
        .cnt_o (hit_cnt)
    );

    l2_stat_counter #(.W(CNT_W)) u_read_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (rsp_valid & is_l1 & (cmd_q != CMD_DWRITE)),
        .clr_i (clr_stats),
        .cnt_o (read_cnt)
    );

    l2_stat_counter #(.W(CNT_W)) u_write_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (rsp_valid & is_l1 & (cmd_q == CMD_DWRITE)),
        .clr_i (clr_stats),
        .cnt_o (write_cnt)
    );

endmodule

// File: tb/tb_l2_req_sequencer.sv
// Bench for l2_req_sequencer: a background array responder answers lookups
// and fills from a plan queue; each test pushes expected operations to a
// scoreboard and compares them against the responses observed.
module tb_l2_req_sequencer;

    localparam int CW   = 4;
    localparam int MAXC = 15;
    localparam logic [1:0] S_D = 2'd0;
    localparam logic [1:0] S_I = 2'd1;
    localparam logic [1:0] S_S = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        l1d_valid = 1'b0, l1d_we = 1'b0;
    logic [31:0] l1d_addr = '0;
    logic        l1d_ready;
    logic        l1i_valid = 1'b0;
    logic [31:0] l1i_addr = '0;
    logic        l1i_ready;
    logic        snp_valid = 1'b0;
    logic [1:0]  snp_op = '0;
    logic [31:0] snp_addr = '0;
    logic        snp_ready;
    logic        lk_valid;
    logic [3:0]  lk_cmd;
    logic [31:0] lk_addr;
    logic        lk_done, lk_hit;
    logic        fill_req;
    logic        fill_done;
    logic        rsp_valid;
    logic [1:0]  rsp_src;
    logic        rsp_hit;
    logic        clr_stats = 1'b0;
    logic [CW-1:0] hit_cnt, read_cnt, write_cnt;

    typedef struct {
        logic [1:0]  src;
        logic [3:0]  cmd;
        logic [31:0] addr;
        logic        hit;
        int          lk_lat;
        int          fill_lat;
    } exp_t;

    typedef struct {
        logic [1:0]  src;
        logic [3:0]  cmd;
        logic [31:0] addr;
        logic        hit;
        int          fills;
        int          lks;
        int          gcyc;
        int          lkcyc;
        int          rcyc;
    } obs_t;

    exp_t exp_q[$];
    exp_t plan_q[$];
    obs_t obs_q[$];

    int checks = 0;
    int errors = 0;
    int m_hit = 0, m_read = 0, m_write = 0;

    l2_req_sequencer #(.ADDR_W(32), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .l1d_valid (l1d_valid),
        .l1d_we    (l1d_we),
        .l1d_addr  (l1d_addr),
        .l1d_ready (l1d_ready),
        .l1i_valid (l1i_valid),
        .l1i_addr  (l1i_addr),
        .l1i_ready (l1i_ready),
        .snp_valid (snp_valid),
        .snp_op    (snp_op),
        .snp_addr  (snp_addr),
        .snp_ready (snp_ready),
        .lk_valid  (lk_valid),
        .lk_cmd    (lk_cmd),
        .lk_addr   (lk_addr),
        .lk_done   (lk_done),
        .lk_hit    (lk_hit),
        .fill_req  (fill_req),
        .fill_done (fill_done),
        .rsp_valid (rsp_valid),
        .rsp_src   (rsp_src),
        .rsp_hit   (rsp_hit),
        .clr_stats (clr_stats),
        .hit_cnt   (hit_cnt),
        .read_cnt  (read_cnt),
        .write_cnt (write_cnt)
    );

    always #5 clk = ~clk;

    // Array model: answers each lookup/fill with the latency and hit of the plan entry
    initial begin
        int   phase;
        int   cnt;
        exp_t cur;
        phase = 0;
        cnt = 0;
        lk_done = 1'b0;
        lk_hit = 1'b0;
        fill_done = 1'b0;
        forever begin
            @(negedge clk);
            lk_done = 1'b0;
            lk_hit = 1'b0;
            fill_done = 1'b0;
            if (!rst_n) begin
                phase = 0;
            end else begin
                if (phase == 0 && lk_valid && plan_q.size() != 0) begin
                    cur = plan_q.pop_front();
                    cnt = 0;
                    phase = 1;
                end
                if (phase == 1) begin
                    if (cnt == cur.lk_lat) begin
                        lk_done = 1'b1;
                        lk_hit = cur.hit;
                        phase = (!cur.hit && cur.src != S_S) ? 2 : 0;
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end else if (phase == 2 && fill_req) begin
                    cnt++;
                    if (cnt == cur.fill_lat) begin
                        fill_done = 1'b1;
                        phase = 0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int sat(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    task automatic push_op(input logic [1:0] src, input logic [3:0] cmd, input logic [31:0] addr,
                           input logic hit, input int lk_lat, input int fill_lat);
        exp_t e;
        e.src = src; e.cmd = cmd; e.addr = addr; e.hit = hit;
        e.lk_lat = lk_lat; e.fill_lat = fill_lat;
        exp_q.push_back(e);
        plan_q.push_back(e);
        if (src != S_S) begin
            if (cmd == 4'd1) m_write = sat(m_write); else m_read = sat(m_read);
            if (hit) m_hit = sat(m_hit);
        end
    endtask

    // Call just after a negedge with requests already driven; cycle 0 is this cycle
    task automatic run_ops(input int n, input int budget, input bit keep, output bit timeout);
        int cyc, got, fills, lks, gcyc, lkcyc;
        bit dd, di, ds;
        obs_t o;
        cyc = 0; got = 0; fills = 0; lks = 0; gcyc = -1; lkcyc = -1;
        dd = 0; di = 0; ds = 0;
        while (got < n && cyc < budget) begin
            #1;
            if (l1d_valid && l1d_ready) begin gcyc = cyc; dd = !keep; end
            if (l1i_valid && l1i_ready) begin gcyc = cyc; di = !keep; end
            if (snp_valid && snp_ready) begin gcyc = cyc; ds = 1'b1; end
            if (lk_valid) begin
                if (lks == 0) lkcyc = cyc;
                lks++;
            end
            if (fill_req) fills++;
            if (rsp_valid) begin
                o.src = rsp_src; o.cmd = lk_cmd; o.addr = lk_addr; o.hit = rsp_hit;
                o.fills = fills; o.lks = lks; o.gcyc = gcyc; o.lkcyc = lkcyc; o.rcyc = cyc;
                obs_q.push_back(o);
                got++; fills = 0; lks = 0;
            end
            cyc++;
            @(negedge clk);
            if (dd) l1d_valid = 1'b0;
            if (di) l1i_valid = 1'b0;
            if (ds) snp_valid = 1'b0;
            dd = 0; di = 0; ds = 0;
        end
        timeout = (got < n);
    endtask

    task automatic clear_stats();
        @(negedge clk);
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        m_hit = 0; m_read = 0; m_write = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        l1d_valid = 1'b1;
        snp_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({l1d_ready, l1i_ready, snp_ready} !== 3'b000) begin
            errors++; $display("FAIL reset_ready: got %b expected 000", {l1d_ready, l1i_ready, snp_ready});
        end
        checks++;
        if ({lk_valid, fill_req, rsp_valid, rsp_hit, rsp_src} !== 6'b0) begin
            errors++; $display("FAIL reset_ctl: got %b expected 000000", {lk_valid, fill_req, rsp_valid, rsp_hit, rsp_src});
        end
        checks++;
        if ({lk_cmd, lk_addr} !== 36'h0) begin
            errors++; $display("FAIL reset_lk: got %h expected 0", {lk_cmd, lk_addr});
        end
        checks++;
        if ({hit_cnt, read_cnt, write_cnt} !== 12'h0) begin
            errors++; $display("FAIL reset_cnt: got %h expected 0", {hit_cnt, read_cnt, write_cnt});
        end
        l1d_valid = 1'b0;
        snp_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_fill();
        bit to;
        int seen;
        push_op(S_D, 4'd0, 32'h1000, 1'b0, 0, 100);
        l1d_valid = 1'b1; l1d_we = 1'b0; l1d_addr = 32'h1000;
        run_ops(1, 6, 1'b0, to);
        #1;
        checks++;
        if (fill_req !== 1'b1) begin
            errors++; $display("FAIL midfill_pending: fill_req got %b expected 1", fill_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (fill_req !== 1'b0) begin
            errors++; $display("FAIL midfill_abort: fill_req got %b expected 0", fill_req);
        end
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            if (rsp_valid || lk_valid || fill_req) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL midfill_norsp: active cycles got %0d expected 0", seen);
        end
        checks++;
        if ({hit_cnt, read_cnt, write_cnt} !== 12'h0) begin
            errors++; $display("FAIL midfill_cnt: got %h expected 0", {hit_cnt, read_cnt, write_cnt});
        end
        void'(exp_q.pop_front());
        plan_q.delete();
        m_hit = 0; m_read = 0; m_write = 0;
        @(negedge clk);
    endtask

    task automatic test_data_read_hit();
        bit to;
        exp_t e;
        obs_t o;
        clear_stats();
        push_op(S_D, 4'd0, 32'h0000_1A40, 1'b1, 0, 0);
        l1d_valid = 1'b1; l1d_we = 1'b0; l1d_addr = 32'h0000_1A40;
        run_ops(1, 20, 1'b0, to);
        checks++;
        if (to) begin
            errors++; $display("FAIL dread_timeout: responses got 0 expected 1");
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if ({o.src, o.cmd, o.addr, o.hit} !== {e.src, e.cmd, e.addr, e.hit}) begin
                errors++; $display("FAIL dread_rsp: got %h expected %h", {o.src, o.cmd, o.addr, o.hit}, {e.src, e.cmd, e.addr, e.hit});
            end
            checks++;
            if (o.gcyc != 0 || o.lkcyc != 1 || o.rcyc != 2) begin
                errors++; $display("FAIL dread_latency: got grant %0d lk %0d rsp %0d expected 0 1 2", o.gcyc, o.lkcyc, o.rcyc);
            end
        end
        checks++;
        if ({read_cnt, hit_cnt, write_cnt} !== {4'd1, 4'd1, 4'd0}) begin
            errors++; $display("FAIL dread_cnt: got %h expected 110", {read_cnt, hit_cnt, write_cnt});
        end
    endtask

    task automatic test_instr_miss();
        bit to;
        exp_t e;
        obs_t o;
        clear_stats();
        push_op(S_I, 4'd2, 32'h2000, 1'b0, 2, 5);
        l1i_valid = 1'b1; l1i_addr = 32'h2000;
        run_ops(1, 40, 1'b0, to);
        checks++;
        if (to) begin
            errors++; $display("FAIL imiss_timeout: responses got 0 expected 1");
        end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if ({o.src, o.cmd, o.addr, o.hit} !== {e.src, e.cmd, e.addr, e.hit}) begin
                errors++; $display("FAIL imiss_rsp: got %h expected %h", {o.src, o.cmd, o.addr, o.hit}, {e.src, e.cmd, e.addr, e.hit});
            end
            checks++;
            if (o.fills != 5 || o.lks != 3) begin
                errors++; $display("FAIL imiss_timing: got fill %0d lk %0d cycles expected 5 3", o.fills, o.lks);
            end
        end
        checks++;
        if ({read_cnt, hit_cnt, write_cnt} !== {4'd1, 4'd0, 4'd0}) begin
            errors++; $display("FAIL imiss_cnt: got %h expected 100", {read_cnt, hit_cnt, write_cnt});
        end
    endtask

    task automatic test_snoop_priority();
        bit to;
        exp_t e;
        obs_t o;
        int prev;
        clear_stats();
        push_op(S_S, 4'd6, 32'h3000, 1'b0, 1, 0);
        push_op(S_D, 4'd1, 32'h4000, 1'b1, 0, 0);
        push_op(S_I, 4'd2, 32'h5000, 1'b0, 0, 2);
        snp_valid = 1'b1; snp_op = 2'd3; snp_addr = 32'h3000;
        l1d_valid = 1'b1; l1d_we = 1'b1; l1d_addr = 32'h4000;
        l1i_valid = 1'b1; l1i_addr = 32'h5000;
        run_ops(3, 60, 1'b0, to);
        checks++;
        if (to) begin
            errors++; $display("FAIL prio_timeout: responses got %0d expected 3", obs_q.size());
        end
        prev = -1;
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if ({o.src, o.cmd, o.addr, o.hit} !== {e.src, e.cmd, e.addr, e.hit}) begin
                errors++; $display("FAIL prio_rsp: got %h expected %h", {o.src, o.cmd, o.addr, o.hit}, {e.src, e.cmd, e.addr, e.hit});
            end
            checks++;
            if (o.fills != ((e.hit || e.src == S_S) ? 0 : e.fill_lat)) begin
                errors++; $display("FAIL prio_fill: got %0d fill cycles expected %0d", o.fills, (e.hit || e.src == S_S) ? 0 : e.fill_lat);
            end
            prev = o.rcyc;
        end
        exp_q.delete(); obs_q.delete(); plan_q.delete();
        checks++;
        if ({read_cnt, hit_cnt, write_cnt} !== {4'd1, 4'd1, 4'd1}) begin
            errors++; $display("FAIL prio_cnt: got %h expected 111", {read_cnt, hit_cnt, write_cnt});
        end
        l1d_we = 1'b0;
    endtask

    task automatic test_snoop_cmds();
        bit to;
        exp_t e;
        obs_t o;
        clear_stats();
        for (int i = 0; i < 4; i++) begin
            push_op(S_S, 4'(3 + i), 32'h7000 + 32'(i * 64), 1'(i % 2), 0, 0);
            snp_valid = 1'b1; snp_op = 2'(i); snp_addr = 32'h7000 + 32'(i * 64);
            run_ops(1, 20, 1'b0, to);
            checks++;
            if (to) begin
                errors++; $display("FAIL snpcmd_timeout: op %0d got no response", i);
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                checks++;
                if ({o.src, o.cmd, o.addr, o.hit} !== {e.src, e.cmd, e.addr, e.hit}) begin
                    errors++; $display("FAIL snpcmd_rsp: got %h expected %h", {o.src, o.cmd, o.addr, o.hit}, {e.src, e.cmd, e.addr, e.hit});
                end
            end
        end
        checks++;
        if ({read_cnt, hit_cnt, write_cnt} !== 12'h0) begin
            errors++; $display("FAIL snpcmd_cnt: got %h expected 000", {read_cnt, hit_cnt, write_cnt});
        end
    endtask

    task automatic test_round_robin();
        bit to;
        exp_t e;
        obs_t o;
        int prev_rsp;
        clear_stats();
        push_op(S_D, 4'd0, 32'h100, 1'b1, 0, 0);
        push_op(S_I, 4'd2, 32'h200, 1'b0, 0, 1);
        push_op(S_D, 4'd0, 32'h100, 1'b1, 1, 0);
        push_op(S_I, 4'd2, 32'h200, 1'b1, 0, 0);
        l1d_valid = 1'b1; l1d_we = 1'b0; l1d_addr = 32'h100;
        l1i_valid = 1'b1; l1i_addr = 32'h200;
        run_ops(4, 80, 1'b1, to);
        l1d_valid = 1'b0;
        l1i_valid = 1'b0;
        checks++;
        if (to) begin
            errors++; $display("FAIL rr_timeout: responses got %0d expected 4", obs_q.size());
        end
        prev_rsp = -1;
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if ({o.src, o.cmd, o.addr, o.hit} !== {e.src, e.cmd, e.addr, e.hit}) begin
                errors++; $display("FAIL rr_order: got %h expected %h", {o.src, o.cmd, o.addr, o.hit}, {e.src, e.cmd, e.addr, e.hit});
            end
            checks++;
            if (o.gcyc != prev_rsp + 1) begin
                errors++; $display("FAIL rr_regrant: grant cycle got %0d expected %0d", o.gcyc, prev_rsp + 1);
            end
            prev_rsp = o.rcyc;
        end
        exp_q.delete(); obs_q.delete(); plan_q.delete();
        @(negedge clk);
        checks++;
        if ({read_cnt, hit_cnt, write_cnt} !== {4'd4, 4'd3, 4'd0}) begin
            errors++; $display("FAIL rr_cnt: got %h expected 430", {read_cnt, hit_cnt, write_cnt});
        end
    endtask

    task automatic test_saturation_clear();
        bit to;
        int tos;
        exp_t e;
        clear_stats();
        tos = 0;
        for (int i = 0; i < 17; i++) begin
            push_op(S_D, 4'd1, 32'h8000 + 32'(i * 64), 1'b1, 0, 0);
            l1d_valid = 1'b1; l1d_we = 1'b1; l1d_addr = 32'h8000 + 32'(i * 64);
            run_ops(1, 20, 1'b0, to);
            if (to) tos++;
        end
        exp_q.delete(); obs_q.delete(); plan_q.delete();
        checks++;
        if (tos != 0) begin
            errors++; $display("FAIL sat_timeout: timed out ops got %0d expected 0", tos);
        end
        checks++;
        if ({write_cnt, hit_cnt, read_cnt} !== {4'(m_write), 4'(m_hit), 4'(m_read)} || m_write != 15) begin
            errors++; $display("FAIL sat_cnt: got %h expected %h", {write_cnt, hit_cnt, read_cnt}, {4'(m_write), 4'(m_hit), 4'(m_read)});
        end
        // one more write hit with clr_stats asserted during its response cycle
        push_op(S_D, 4'd1, 32'h9000, 1'b1, 0, 0);
        l1d_valid = 1'b1; l1d_addr = 32'h9000;
        @(negedge clk);
        l1d_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1) begin
            errors++; $display("FAIL clr_rsp: rsp_valid/rsp_hit got %b%b expected 11", rsp_valid, rsp_hit);
        end
        e = exp_q.pop_front();
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        m_hit = 0; m_read = 0; m_write = 0;
        checks++;
        if ({write_cnt, hit_cnt, read_cnt} !== 12'h0) begin
            errors++; $display("FAIL clr_wins: got %h expected 000", {write_cnt, hit_cnt, read_cnt});
        end
        l1d_we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reset_mid_fill();
        test_data_read_hit();
        test_instr_miss();
        test_snoop_priority();
        test_snoop_cmds();
        test_round_robin();
        test_saturation_clear();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
